// File: rtl/sample_fifo.sv
// Single-clock sample FIFO: (DEPTH-1)-word RAM plus a show-ahead output register.
// Define SAMPLE_FIFO_DROP_COUNT_EN to add the saturating droppedCount output.
module sample_fifo #(
    parameter int DATA_WIDTH         = 10,
    parameter int ADDR_WIDTH         = 13,
    parameter int ALMOST_EMPTY_LEVEL = 8,
    parameter int HALF_FULL_LEVEL    = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] inputData,
    input  logic                  readAck,
    output logic [DATA_WIDTH-1:0] outputData,
    output logic                  outputValid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty_flag,
    output logic                  almostEmpty_flag,
    output logic                  halfFull_flag,
    output logic                  full_flag,
    output logic                  overflow_flag,
    output logic                  underflow_flag
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0]           droppedCount
`endif
);

    localparam int                    DEPTH      = 1 << ADDR_WIDTH;
    localparam int                    RAM_WORDS  = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 2);
    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [31:0]           AE_LIMIT   = 32'(ALMOST_EMPTY_LEVEL);
    localparam logic [31:0]           HF_LIMIT   = 32'(HALF_FULL_LEVEL);
    localparam logic                  AE_RESET   = (ALMOST_EMPTY_LEVEL > 0);

    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  half_full_q, half_full_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
    logic [15:0]           dropped_q, dropped_d;
`endif

    logic                  wr_accept;
    logic                  pop;
    logic                  load;
    logic                  mem_we;
    logic [ADDR_WIDTH:0]   ram_count;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // The output register refills from RAM whenever it is empty or being popped.
    always_comb begin
        wr_accept = writeEnable && !full_q;
        pop       = readAck && out_valid_q;
        ram_count = level_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
        load      = (ram_count != '0) && (!out_valid_q || pop);
        mem_we    = wr_accept && !clear;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
        dropped_d   = dropped_q;
`endif

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
            dropped_d   = '0;
`endif
        end else begin
            if (wr_accept) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (load) begin
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                out_data_d  = mem[rd_ptr_q];
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
            case ({wr_accept, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (writeEnable && full_q) begin
                overflow_d = 1'b1;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
                if (dropped_q != 16'hFFFF) begin
                    dropped_d = dropped_q + 16'd1;
                end
`endif
            end
            if (readAck && !out_valid_q) begin
                underflow_d = 1'b1;
            end
        end

        empty_d        = (level_d == '0);
        almost_empty_d = (32'(level_d) < AE_LIMIT);
        half_full_d    = (32'(level_d) > HF_LIMIT);
        full_d         = (level_d == FULL_LEVEL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= AE_RESET;
            half_full_q    <= 1'b0;
            full_q         <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
            dropped_q      <= '0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            half_full_q    <= half_full_d;
            full_q         <= full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
            dropped_q      <= dropped_d;
`endif
        end
    end

    // RAM has no reset so it can map onto block memory.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= inputData;
        end
    end

    assign outputData       = out_data_q;
    assign outputValid      = out_valid_q;
    assign level            = level_q;
    assign empty_flag       = empty_q;
    assign almostEmpty_flag = almost_empty_q;
    assign halfFull_flag    = half_full_q;
    assign full_flag        = full_q;
    assign overflow_flag    = overflow_q;
    assign underflow_flag   = underflow_q;
`ifdef SAMPLE_FIFO_DROP_COUNT_EN
    assign droppedCount     = dropped_q;
`endif

endmodule

// File: doc/sample_fifo.md
Name: sample_fifo

Overview:
- Parametrised single-clock sample FIFO with its own inferred RAM storage and a first-word-fall-through output stage.
- Sits between the ADC sample capture and the USB/GPIF output logic, replacing the fixed 10-bit, 8192-word buffer.
- Adds programmable thresholds, an exact fill level, write enable, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 10: sample word width in bits.
- ADDR_WIDTH, 13: log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8192 words).
- ALMOST_EMPTY_LEVEL, 8: almostEmpty_flag is set while level < this value.
- HALF_FULL_LEVEL, 4096: halfFull_flag is set while level > this value.

Ports:
- clock, input, 1: single system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous flush; empties the FIFO and clears the sticky flags.
- writeEnable, input, 1: write request for inputData in this cycle.
- inputData, input, DATA_WIDTH: sample to store.
- readAck, input, 1: consumes the word currently on outputData (show-ahead acknowledge).
- outputData, output, DATA_WIDTH: head word; valid while outputValid=1.
- outputValid, output, 1: head word present.
- level, output, ADDR_WIDTH+1: number of words held, counting the output stage.
- empty_flag, output, 1: level==0.
- almostEmpty_flag, output, 1: level < ALMOST_EMPTY_LEVEL.
- halfFull_flag, output, 1: level > HALF_FULL_LEVEL.
- full_flag, output, 1: level==DEPTH.
- overflow_flag, output, 1: sticky; a write was dropped.
- underflow_flag, output, 1: sticky; readAck was asserted while outputValid=0.

Behaviour:
- Reset values:
  - level=0, outputValid=0, outputData=0.
  - empty_flag=1, almostEmpty_flag=1 (when ALMOST_EMPTY_LEVEL>0).
  - halfFull_flag=0, full_flag=0, overflow_flag=0, underflow_flag=0.
  - Read and write pointers = 0.
- Reset is asynchronous in assertion; pointers and flags leave reset on the first clock edge after deassertion.
- Storage:
  - DEPTH-1 RAM words plus one output register, giving DEPTH total.
  - Pointers are ADDR_WIDTH bits and wrap from DEPTH-2 to 0 (the RAM region is not a power of two; wrap is an explicit compare).
  - Implementers may instead use a DEPTH-word RAM with a prefetch register, provided the total capacity is exactly DEPTH and the latency below holds.
- Write is accepted iff writeEnable=1 and full_flag=0 at the edge.
  - A write while full is dropped and sets overflow_flag on that edge.
  - A simultaneous readAck does not rescue a write while full.
- Read:
  - readAck with outputValid=1 pops the head word on the edge.
  - The next word appears on outputData on the same edge if the RAM is non-empty, via a registered read addressed from the next pointer.
  - readAck with outputValid=0 is ignored and sets underflow_flag.
- Latency: a write into an empty FIFO at edge N gives outputValid=1 and outputData=that word after edge N+1 (2-cycle fall-through).
- level:
  - Increments on an accepted write and decrements on a valid pop.
  - Unchanged when both occur in the same cycle.
  - level counts a word from the write edge, even before it reaches the output stage.
- Flags:
  - All flags are registered and computed from the next value of level, so they always agree with level in the same cycle.
  - Thresholds are compared with strict inequality, as listed under Ports.
- clear=1:
  - On the edge, pointers go to 0, level=0, outputValid=0, and flags return to their reset values, including both sticky flags.
  - Writes and reads in that cycle are discarded.
  - clear has priority over writeEnable and readAck.
- Simultaneous read and write at level==1: the new word becomes the head via the RAM path. A 1-cycle outputValid gap is permitted only in this case; level stays 1.
- Out-of-range thresholds saturate: ALMOST_EMPTY_LEVEL > DEPTH means the flag is always 1; HALF_FULL_LEVEL >= DEPTH means the flag is always 0.

Optional Feature:
- Macro: SAMPLE_FIFO_DROP_COUNT_EN.
- Defined:
  - Adds output droppedCount, 16 bits, counting dropped writes.
  - The counter saturates at 16'hFFFF.
  - It is cleared by reset and by clear.
- Undefined: the port and counter are absent; overflow_flag alone reports drops.

Test Plan:
- Reset, then write 3 words (0x001, 0x002, 0x003) on consecutive cycles -> outputValid rises after the 2nd edge, outputData=0x001; level=1,2,3; empty_flag 1->0; almostEmpty_flag stays 1.
- Fill to DEPTH with readAck=0, then one more write -> full_flag=1 at level 8192; overflow_flag=1; level stays 8192; droppedCount=1 when SAMPLE_FIFO_DROP_COUNT_EN is defined.
- Fill to 4096, then write 1 more -> halfFull_flag is 0 at 4096 and 1 at 4097; one pop returns it to 0.
- Hold writeEnable=1 and readAck=1 continuously from level 5 for 10000 cycles -> level stays 5; data emerges in order across pointer wrap; no overflow or underflow.
- readAck=1 on an empty FIFO -> underflow_flag=1; level stays 0; a later clear sets underflow_flag=0.
- Mid-stream at level 100, assert clear together with writeEnable and readAck -> next cycle level=0, empty_flag=1, outputValid=0; the next write is readable with 2-cycle latency.
